uart_tx_fifo_cfg: RTL and testbench

//   Parametrised UART transmitter with an input FIFO and per-frame runtime framing control.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_cfg_if.sv | 10 +
 rtl/uart_sync_fifo.sv | 42 ++++
 rtl/uart_tx_fifo_cfg.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, parity encodings and data-width helpers for the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  function automatic logic [2:0] last_bit(input logic [1:0] dbits);
    return 3'd4 + {1'b0, dbits};
  endfunction
  function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction
endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// uart_tx_fifo_cfg_if: push-side handshake and fill level between register block and transmitter
interface uart_tx_fifo_cfg_if #(parameter int FIFO_DEPTH = 4);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [LW-1:0] fifo_level;
  modport master (output in_valid, in_data, input in_ready, fifo_level);
  modport slave  (input in_valid, in_data, output in_ready, fifo_level);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with level count; pushes when full and pops when empty are ignored
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     lvl_q;
  logic              wr_en, rd_en;
  assign full  = lvl_q == LW'(DEPTH);
  assign empty = lvl_q == '0;
  assign level = lvl_q;
  assign rdata = mem_q[rd_q];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  // pointers and level; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(rd_en);
      lvl_q <= lvl_q + LW'(wr_en) - LW'(rd_en);
    end
  // storage needs no reset: entries are only read once written
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: FIFO-fed UART transmitter with per-frame framing; parity only with UART_TX_PARITY_EN
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                b_tick,
  uart_tx_fifo_cfg_if.slave   bus,
  input  logic [1:0]          cfg_dbits,
  input  logic                cfg_stop2,
  input  logic [1:0]          cfg_par,
  output logic                busy,
  output logic                tx_done,
  output logic                tx
);
  localparam int TW = $clog2(OVS);
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    last_q, last_d;
  logic          stop2_q, stop2_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          pop, full, empty, adv, par_en, par_bit;
  logic [7:0]    head;

  uart_sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (bus.fifo_level)
  );

  assign bus.in_ready = !full;
  assign busy         = state_q != IDLE;
  assign tx_done      = done_q;
  assign tx           = tx_q;
  assign adv          = b_tick && tick_q == TW'(OVS - 1);

`ifdef UART_TX_PARITY_EN
  logic pen_q, par_q;
  assign par_en  = pen_q;
  assign par_bit = par_q;
  // parity mode and bit are captured with the byte so later cfg changes cannot disturb the frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pen_q <= 1'b0;
      par_q <= 1'b0;
    end else if (pop) begin
      pen_q <= cfg_par == PAR_EVEN || cfg_par == PAR_ODD;
      par_q <= ^(head & dbits_mask(cfg_dbits)) ^ (cfg_par == PAR_ODD);
    end
`else
  logic unused_par;
  assign unused_par = ^cfg_par;
  assign par_en     = 1'b0;
  assign par_bit    = 1'b0;
`endif

  // next state: bit timing on b_tick, pop into the shifter from IDLE or straight out of STOP
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    last_d  = last_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (b_tick && state_q != IDLE) tick_d = adv ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: pop = !empty;
      START: if (adv) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (adv) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == last_q) begin
          state_d = par_en ? PARITY : STOP;
          bit_d   = '0;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (adv) state_d = STOP;
`endif
      STOP: if (adv) begin
        if (stop2_q && !bit_q[0]) bit_d = 3'd1;
        else begin
          done_d  = 1'b1;
          state_d = IDLE;
          pop     = !empty;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shift_d = head;
      last_d  = last_bit(cfg_dbits);
      stop2_d = cfg_stop2;
      tick_d  = '0;
      bit_d   = '0;
      state_d = START;
    end
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_bit : 1'b1;
  end

  // state registers; reset drops the frame in flight and idles the line high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      tick_q  <= '0;
      bit_q   <= '0;
      last_q  <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed frame vectors plus FIFO, reset, reconfiguration and tick-stall sequences
module tb_uart_tx_fifo_cfg;
  typedef struct {
    logic [1:0]  dbits;
    logic        stop2;
    logic [1:0]  par;
    logic [7:0]  data;
    int          n;
    logic [15:0] exp;
  } vec_t;

  logic       clk = 1'b0, reset = 1'b1, b_tick = 1'b0, tick_en = 1'b1;
  logic [1:0] cfg_dbits = 2'b11, cfg_par = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       busy, tx_done, tx;
  int         errors = 0, checks = 0, done_cnt = 0, tcnt = 0;
  vec_t       v [6];
  logic [7:0] seq [6];

  uart_tx_fifo_cfg_if #(.FIFO_DEPTH(4)) bus ();

  uart_tx_fifo_cfg #(.OVS(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_tick    (b_tick),
    .bus       (bus.slave),
    .cfg_dbits (cfg_dbits),
    .cfg_stop2 (cfg_stop2),
    .cfg_par   (cfg_par),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt   = (tcnt + 1) % 4;
    b_tick = tick_en && tcnt == 0;
    if (!reset && tx_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      do @(posedge clk); while (!b_tick);
    end
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int c = 0;
    while (bus.in_ready !== 1'b1 && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    check("push_wait", c < 2000, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_fall();
    int c = 0;
    while (tx !== 1'b0 && c < 4000) begin
      @(posedge clk); #1; c++;
    end
    check("fall_seen", c < 4000, 1);
  endtask

  task automatic capture(input int n, output logic [15:0] got, output logic done_ok);
    got = '0;
    wait_fall();
    for (int i = 0; i < n; i++) begin
      wait_ticks(i == 0 ? 8 : 16);
      got[i] = tx;
    end
    wait_ticks(8);
    done_ok = tx_done;
  endtask

  initial begin
    logic [15:0] got;
    logic        dn, ok;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    v[0] = '{2'b11, 1'b0, 2'b00, 8'hA5, 10, 16'h034A};
`ifdef UART_TX_PARITY_EN
    v[1] = '{2'b00, 1'b1, 2'b01, 8'h1F, 9, 16'h01FE};
    v[2] = '{2'b00, 1'b1, 2'b10, 8'h1F, 9, 16'h01BE};
`else
    v[1] = '{2'b00, 1'b1, 2'b01, 8'h1F, 8, 16'h00FE};
    v[2] = '{2'b00, 1'b1, 2'b10, 8'h1F, 8, 16'h00FE};
`endif
    v[3] = '{2'b10, 1'b0, 2'b00, 8'h80, 9, 16'h0100};
    v[4] = '{2'b01, 1'b0, 2'b00, 8'h2A, 8, 16'h00D4};
    v[5] = '{2'b11, 1'b0, 2'b11, 8'h3C, 10, 16'h0278};
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_done", tx_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_level", bus.fifo_level, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cfg_dbits = v[i].dbits;
      cfg_stop2 = v[i].stop2;
      cfg_par   = v[i].par;
      push(v[i].data);
      capture(v[i].n, got, dn);
      check($sformatf("vec%0d_frame", i), got, v[i].exp);
      check($sformatf("vec%0d_done", i), dn, 1);
      check($sformatf("vec%0d_idle", i), busy, 0);
      check($sformatf("vec%0d_level", i), bus.fifo_level, 0);
    end

    cfg_dbits = 2'b11; cfg_stop2 = 1'b0; cfg_par = 2'b00;
    fork
      begin
        for (int i = 0; i < 5; i++) push(seq[i]);
        check("full_level", bus.fifo_level, 4);
        check("full_ready", bus.in_ready, 0);
        push(seq[5]);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          capture(10, got, dn);
          check($sformatf("burst%0d_frame", k), got, {6'b0, 1'b1, seq[k], 1'b0});
          check($sformatf("burst%0d_done", k), dn, 1);
          if (k < 5) check($sformatf("burst%0d_contig", k), tx, 0);
        end
      end
    join
    check("burst_idle", busy, 0);

    push(8'h00);
    push(8'h5A);
    wait_ticks(40);
    check("mid_data_tx", tx, 0);
    check("mid_data_level", bus.fifo_level, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_level", bus.fifo_level, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    push(8'hA5);
    capture(10, got, dn);
    check("post_rst_frame", got, 16'h034A);
    check("post_rst_done", dn, 1);

    fork
      begin
        push(8'h01);
        push(8'h01);
        wait_ticks(40);
        cfg_dbits = 2'b10;
      end
      begin
        capture(10, got, dn);
        check("cfg8_frame", got, 16'h0202);
        check("cfg8_done", dn, 1);
        capture(9, got, dn);
        check("cfg7_frame", got, 16'h0102);
        check("cfg7_done", dn, 1);
      end
    join

    cfg_dbits = 2'b11;
    push(8'h01);
    wait_fall();
    wait_ticks(4);
    tick_en = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx !== 1'b0 || busy !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
    end
    check("stall_hold", ok, 1);
    tick_en = 1'b1;
    wait_ticks(11);
    check("resume_start", tx, 0);
    wait_ticks(1);
    check("resume_bit0", tx, 1);
    wait_ticks(144);
    check("resume_done", tx_done, 1);

    @(negedge clk); #1;
    check("done_pulses", done_cnt, 16);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
